// File: rtl/lc3_mem_bridge.sv
// lc3_mem_bridge: LC-3 memory port to RAMHelper bridge with an optional
// memory-mapped device page (KBSR/KBDR/DSR/DDR/MCR), enabled by LC3_MMIO_EN.
`default_nettype none

module lc3_mem_bridge #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] ram_ridx,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_widx,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    input  logic              kb_valid,
    output logic              kb_ready,
    input  logic [7:0]        kb_data,
    output logic              dsp_valid,
    input  logic              dsp_ready,
    output logic [7:0]        dsp_data,
    output logic              kb_irq,
    output logic              run
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic              is_dev;
    logic              ram_wr;
    logic [DATA_W-1:0] dev_rdata;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;

    // RAM port is driven straight from the request in the accept cycle so the
    // RAM's one-cycle read latency overlaps the handshake.
    assign ram_wr    = accept & req_wen & ~is_dev;
    assign ram_wen   = ram_wr;
    assign ram_ridx  = accept ? req_addr : addr_q;
    assign ram_widx  = ram_wr ? req_addr : widx_q;
    assign ram_wdata = ram_wr ? req_wdata : wdata_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        if (ram_wr) begin
            widx_d  = req_addr;
            wdata_d = req_wdata;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_dev) begin
                        rdata_d = req_wen ? '0 : dev_rdata;
                        state_d = ST_RESP;
                    end else if (req_wen) begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        addr_d  = req_addr;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                rdata_d = ram_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef LC3_MMIO_EN
    localparam logic [ADDR_W-1:0] KBSR_ADDR = ADDR_W'(16'hFE00);
    localparam logic [ADDR_W-1:0] KBDR_ADDR = ADDR_W'(16'hFE02);
    localparam logic [ADDR_W-1:0] DSR_ADDR  = ADDR_W'(16'hFE04);
    localparam logic [ADDR_W-1:0] DDR_ADDR  = ADDR_W'(16'hFE06);
    localparam logic [ADDR_W-1:0] MCR_ADDR  = ADDR_W'(16'hFFFE);

    logic       kb_full_q, kb_full_d;
    logic       kb_ie_q, kb_ie_d;
    logic [7:0] kb_byte_q, kb_byte_d;
    logic       dsp_valid_q, dsp_valid_d;
    logic [7:0] dsp_data_q, dsp_data_d;
    logic       run_q, run_d;
    logic       dev_rd, dev_wr;

    assign is_dev    = &req_addr[ADDR_W-1:9];
    assign dev_rd    = accept & is_dev & ~req_wen;
    assign dev_wr    = accept & is_dev & req_wen;
    assign kb_ready  = ~kb_full_q;
    assign kb_irq    = kb_full_q & kb_ie_q;
    assign dsp_valid = dsp_valid_q;
    assign dsp_data  = dsp_data_q;
    assign run       = run_q;

    always_comb begin
        dev_rdata = '0;
        case (req_addr)
            KBSR_ADDR: dev_rdata = DATA_W'({kb_full_q, kb_ie_q, 14'b0});
            KBDR_ADDR: dev_rdata = DATA_W'({8'h00, kb_byte_q});
            DSR_ADDR:  dev_rdata = DATA_W'({~dsp_valid_q, 15'b0});
            MCR_ADDR:  dev_rdata = DATA_W'({run_q, 15'b0});
            default:   dev_rdata = '0;
        endcase
    end

    always_comb begin
        kb_full_d   = kb_full_q;
        kb_ie_d     = kb_ie_q;
        kb_byte_d   = kb_byte_q;
        dsp_valid_d = dsp_valid_q;
        dsp_data_d  = dsp_data_q;
        run_d       = run_q;
        if (dev_rd && req_addr == KBDR_ADDR) begin
            kb_full_d = 1'b0;
        end
        // Push is only possible while empty, so it never races a KBDR clear.
        if (kb_valid && !kb_full_q) begin
            kb_full_d = 1'b1;
            kb_byte_d = kb_data;
        end
        if (dsp_valid_q && dsp_ready) begin
            dsp_valid_d = 1'b0;
        end
        if (dev_wr) begin
            case (req_addr)
                KBSR_ADDR: kb_ie_d = req_wdata[14];
                DDR_ADDR: begin
                    if (!dsp_valid_q) begin
                        dsp_valid_d = 1'b1;
                        dsp_data_d  = req_wdata[7:0];
                    end
                end
                MCR_ADDR:  run_d = req_wdata[15];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_full_q   <= 1'b0;
            kb_ie_q     <= 1'b0;
            kb_byte_q   <= '0;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= '0;
            run_q       <= 1'b1;
        end else begin
            kb_full_q   <= kb_full_d;
            kb_ie_q     <= kb_ie_d;
            kb_byte_q   <= kb_byte_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_data_q  <= dsp_data_d;
            run_q       <= run_d;
        end
    end
`else
    logic unused_dev_inputs;

    assign is_dev            = 1'b0;
    assign dev_rdata         = '0;
    assign kb_ready          = 1'b0;
    assign kb_irq            = 1'b0;
    assign dsp_valid         = 1'b0;
    assign dsp_data          = '0;
    assign run               = 1'b1;
    assign unused_dev_inputs = ^{kb_valid, kb_data, dsp_ready};
`endif

endmodule

`default_nettype wire

// File: tb/tb_lc3_mem_bridge.sv
// Scoreboard bench for lc3_mem_bridge with a behavioural RAMHelper model.
`default_nettype none

module tb_lc3_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [15:0] resp_rdata;
    logic [15:0] ram_ridx;
    logic [15:0] ram_rdata;
    logic [15:0] ram_widx;
    logic [15:0] ram_wdata;
    logic        ram_wen;
    logic        kb_valid = 1'b0;
    logic        kb_ready;
    logic [7:0]  kb_data = '0;
    logic        dsp_valid;
    logic        dsp_ready = 1'b0;
    logic [7:0]  dsp_data;
    logic        kb_irq;
    logic        run;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    logic [15:0] mem [0:65535];
    logic [15:0] ram_q = '0;
    logic [15:0] glitch = '0;

    always #5 clk = ~clk;

    lc3_mem_bridge #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .ram_ridx(ram_ridx), .ram_rdata(ram_rdata), .ram_widx(ram_widx),
        .ram_wdata(ram_wdata), .ram_wen(ram_wen),
        .kb_valid(kb_valid), .kb_ready(kb_ready), .kb_data(kb_data),
        .dsp_valid(dsp_valid), .dsp_ready(dsp_ready), .dsp_data(dsp_data),
        .kb_irq(kb_irq), .run(run)
    );

    // RAMHelper: synchronous write, one-cycle registered read
    initial for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    always @(posedge clk) begin
        if (ram_wen) mem[ram_widx] <= ram_wdata;
        ram_q <= mem[ram_ridx];
    end
    assign ram_rdata = ram_q ^ glitch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every completed response
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {16'h0, resp_rdata}, 32'hDEAD_BEEF);
            end else begin
                chk("resp_rdata", {16'h0, resp_rdata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic issue(input logic wen, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic exp_wen);
        int n;
        n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'h0, req_ready}, 32'h1);
        chk("ram_wen_accept", {31'h0, ram_wen}, {31'h0, exp_wen});
        if (exp_wen) begin
            chk("ram_widx", {16'h0, ram_widx}, {16'h0, addr});
            chk("ram_wdata", {16'h0, ram_wdata}, {16'h0, wdata});
        end
        if (!wen) chk("ram_ridx", {16'h0, ram_ridx}, {16'h0, addr});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int exp_lat);
        int lat;
        lat = 1;
        @(negedge clk);
        chk("ram_wen_after", {31'h0, ram_wen}, 32'h0);
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic do_req(input logic wen, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_rdata, input int exp_lat, input logic exp_wen);
        exp_q.push_back(exp_rdata);
        issue(wen, addr, wdata, exp_wen);
        wait_resp(exp_lat);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", {16'h0, resp_rdata}, 32'h0);
        chk("rst_ram_wen", {31'h0, ram_wen}, 32'h0);
        chk("rst_ram_widx", {16'h0, ram_widx}, 32'h0);
        chk("rst_ram_wdata", {16'h0, ram_wdata}, 32'h0);
        chk("rst_dsp_valid", {31'h0, dsp_valid}, 32'h0);
        chk("rst_dsp_data", {24'h0, dsp_data}, 32'h0);
        chk("rst_kb_irq", {31'h0, kb_irq}, 32'h0);
        chk("rst_run", {31'h0, run}, 32'h1);
`ifdef LC3_MMIO_EN
        chk("rst_kb_ready", {31'h0, kb_ready}, 32'h1);
`else
        chk("rst_kb_ready", {31'h0, kb_ready}, 32'h0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // RAM write then read back
        do_req(1'b1, 16'h3000, 16'h1234, 16'h0000, 1, 1'b1);
        do_req(1'b0, 16'h3000, 16'h0000, 16'h1234, 2, 1'b0);
        do_req(1'b1, 16'h0000, 16'hFFFF, 16'h0000, 1, 1'b1);
        do_req(1'b1, 16'hFDFF, 16'hA5A5, 16'h0000, 1, 1'b1);
        do_req(1'b0, 16'h0000, 16'h0000, 16'hFFFF, 2, 1'b0);
        do_req(1'b0, 16'hFDFF, 16'h0000, 16'hA5A5, 2, 1'b0);

        // Stalled response while ram_rdata wanders
        resp_ready = 1'b0;
        exp_q.push_back(16'h1234);
        issue(1'b0, 16'h3000, 16'h0000, 1'b0);
        wait_resp(2);
        glitch = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rdata", {16'h0, resp_rdata}, 32'h1234);
            chk("stall_valid", {31'h0, resp_valid}, 32'h1);
            chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
            glitch = glitch ^ 16'h0F0F;
        end
        glitch = '0;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        wait_idle();

`ifdef LC3_MMIO_EN
        // Keyboard
        @(posedge clk); #1;
        kb_valid = 1'b1; kb_data = 8'h41;
        @(posedge clk); #1;
        kb_valid = 1'b0;
        chk("kb_ready_full", {31'h0, kb_ready}, 32'h0);
        do_req(1'b0, 16'hFE00, 16'h0000, 16'h8000, 1, 1'b0);
        do_req(1'b0, 16'hFE02, 16'h0000, 16'h0041, 1, 1'b0);
        do_req(1'b0, 16'hFE00, 16'h0000, 16'h0000, 1, 1'b0);
        chk("kb_ready_empty", {31'h0, kb_ready}, 32'h1);
        @(posedge clk); #1;
        kb_valid = 1'b1; kb_data = 8'h5A;
        @(posedge clk); #1;
        kb_valid = 1'b0;
        do_req(1'b1, 16'hFE00, 16'h4000, 16'h0000, 1, 1'b0);
        chk("kb_irq_set", {31'h0, kb_irq}, 32'h1);
        do_req(1'b0, 16'hFE00, 16'h0000, 16'hC000, 1, 1'b0);
        do_req(1'b0, 16'hFE02, 16'h0000, 16'h005A, 1, 1'b0);
        chk("kb_irq_clr", {31'h0, kb_irq}, 32'h0);

        // Display
        dsp_ready = 1'b0;
        do_req(1'b1, 16'hFE06, 16'h0048, 16'h0000, 1, 1'b0);
        chk("dsp_valid_set", {31'h0, dsp_valid}, 32'h1);
        do_req(1'b0, 16'hFE04, 16'h0000, 16'h0000, 1, 1'b0);
        do_req(1'b1, 16'hFE06, 16'h0049, 16'h0000, 1, 1'b0);
        chk("dsp_data_kept", {24'h0, dsp_data}, 32'h48);
        @(posedge clk); #1;
        dsp_ready = 1'b1;
        @(negedge clk);
        chk("dsp_data_out", {24'h0, dsp_data}, 32'h48);
        @(posedge clk); #1;
        dsp_ready = 1'b0;
        chk("dsp_valid_clr", {31'h0, dsp_valid}, 32'h0);
        do_req(1'b0, 16'hFE04, 16'h0000, 16'h8000, 1, 1'b0);

        // MCR and unmapped device page
        do_req(1'b1, 16'hFFFE, 16'h0000, 16'h0000, 1, 1'b0);
        chk("run_clr", {31'h0, run}, 32'h0);
        do_req(1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1, 1'b0);
        do_req(1'b1, 16'hFFFE, 16'h8000, 16'h0000, 1, 1'b0);
        chk("run_set", {31'h0, run}, 32'h1);
        do_req(1'b1, 16'hFE08, 16'hBEEF, 16'h0000, 1, 1'b0);
        do_req(1'b0, 16'hFE08, 16'h0000, 16'h0000, 1, 1'b0);

        // Leave a display byte pending for the reset test
        do_req(1'b1, 16'hFE06, 16'h0055, 16'h0000, 1, 1'b0);
        chk("dsp_pending", {31'h0, dsp_valid}, 32'h1);
`else
        // Device page goes to RAM
        do_req(1'b1, 16'hFFFE, 16'h0000, 16'h0000, 1, 1'b1);
        chk("run_tied", {31'h0, run}, 32'h1);
        do_req(1'b1, 16'hFE06, 16'h0048, 16'h0000, 1, 1'b1);
        do_req(1'b0, 16'hFE06, 16'h0000, 16'h0048, 2, 1'b0);
        do_req(1'b0, 16'hFFFE, 16'h0000, 16'h0000, 2, 1'b0);
        chk("dsp_valid_tied", {31'h0, dsp_valid}, 32'h0);
        chk("kb_ready_tied", {31'h0, kb_ready}, 32'h0);
`endif

        // Reset while in RD
        issue(1'b0, 16'h3000, 16'h0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("mid_rst_dsp_valid", {31'h0, dsp_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        do_req(1'b0, 16'h3000, 16'h0000, 16'h1234, 2, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
